// File: rtl/fides_imixcol_serial_if.sv
// Handshake bundle for the column-serial inverse MixColumns block.
// It carries an input stream of shared states and an output stream of results.
interface fides_imixcol_serial_if #(
    parameter int NSH = 3,
    parameter int SW  = 160
);
    logic               in_valid;
    logic               in_ready;
    logic [NSH*SW-1:0]  in_sh;
    logic               out_valid;
    logic               out_ready;
    logic [NSH*SW-1:0]  out_sh;

    modport slave (
        input  in_valid, in_sh, out_ready,
        output in_ready, out_valid, out_sh
    );

    modport master (
        output in_valid, in_sh, out_ready,
        input  in_ready, out_valid, out_sh
    );
endinterface

// File: rtl/fides_imixcol_serial.sv
// Column-serial inverse MixColumns for the threshold-implemented Fides-160 decryption path.
// Each share is transformed on its own, one column per cycle, so share separation is kept.
module fides_imixcol_serial #(
    parameter int NSH  = 3,
    parameter int NCOL = 8,
    parameter int W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    fides_imixcol_serial_if.slave bus,
    output logic                  busy
);
    localparam int CW   = 4 * W;
    localparam int SW   = NCOL * CW;
    localparam int COLW = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam logic [COLW-1:0] LAST_COL = COLW'(NCOL - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            r_state;
    state_e            w_state_nxt;
    logic [COLW-1:0]   r_col;
    logic [NSH*SW-1:0] r_sh;
    logic [NSH*SW-1:0] w_mixed;

    // The matrix is an involution: every output element is the XOR of the other three.
    function automatic logic [CW-1:0] inv_mix_col(input logic [CW-1:0] x);
        logic [CW-1:0] y;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            y[r*W +: W] = x[((r + 1) % 4)*W +: W]
                        ^ x[((r + 2) % 4)*W +: W]
                        ^ x[((r + 3) % 4)*W +: W];
        end
        return y;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // NOTE: every output is defaulted before the case so no path can infer a latch.
    always_comb begin
        w_state_nxt  = r_state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_col == LAST_COL) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_mixed = r_sh;
        for (int s = 0; s < NSH; s++) begin
            w_mixed[s*SW + int'(r_col)*CW +: CW] = inv_mix_col(r_sh[s*SW + int'(r_col)*CW +: CW]);
        end
    end

    // NOTE: the state register is reset too, so a discarded partial result never shows on out_sh.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh  <= '0;
            r_col <= '0;
        end else if (r_state == S_IDLE && bus.in_valid) begin
            r_sh  <= bus.in_sh;
            r_col <= '0;
        end else if (r_state == S_RUN) begin
            r_sh  <= w_mixed;
            r_col <= r_col + COLW'(1);
        end
    end

    assign bus.out_sh = r_sh;
endmodule

// File: tb/tb_fides_imixcol_serial.sv
// Scoreboard bench for fides_imixcol_serial: accepted inputs push a model result,
// a monitor pops and compares on each output handshake.
module tb_fides_imixcol_serial;
    localparam int NSH  = 3;
    localparam int NCOL = 8;
    localparam int W    = 5;
    localparam int SW   = 4 * NCOL * W;
    localparam int TW   = NSH * SW;

    typedef logic [TW-1:0] sh_t;
    typedef logic [SW-1:0] st_t;

    logic clk;
    logic rst;
    logic busy;

    fides_imixcol_serial_if #(.NSH(NSH), .SW(SW)) bus ();

    fides_imixcol_serial #(.NSH(NSH), .NCOL(NCOL), .W(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    int  n_out    = 0;
    int  accept_edge = 0;
    int  last_rise   = -1;
    bit  b2b      = 1'b0;
    bit  prev_ov  = 1'b0;
    sh_t last_out;
    sh_t exp_q[$];

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_vec(input string name, input sh_t act, input sh_t exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: per column, each element is the column XOR with itself removed.
    function automatic st_t ref_mix(input st_t x);
        st_t          y;
        logic [W-1:0] e[4];
        logic [W-1:0] tot;
        y = '0;
        for (int c = 0; c < NCOL; c++) begin
            tot = '0;
            for (int r = 0; r < 4; r++) begin
                e[r] = x[(4*c + r)*W +: W];
                tot  = tot ^ e[r];
            end
            for (int r = 0; r < 4; r++) y[(4*c + r)*W +: W] = tot ^ e[r];
        end
        return y;
    endfunction

    function automatic sh_t ref_mix_sh(input sh_t x);
        sh_t y;
        for (int s = 0; s < NSH; s++) y[s*SW +: SW] = ref_mix(x[s*SW +: SW]);
        return y;
    endfunction

    function automatic st_t xor_shares(input sh_t x);
        st_t v;
        v = '0;
        for (int s = 0; s < NSH; s++) v = v ^ x[s*SW +: SW];
        return v;
    endfunction

    function automatic st_t rand_st();
        st_t v;
        for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic sh_t rand_sh();
        sh_t v;
        for (int s = 0; s < NSH; s++) v[s*SW +: SW] = rand_st();
        return v;
    endfunction

    // Monitor: records accepts into the scoreboard and checks each delivered result.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_mix_sh(bus.in_sh));
                accept_edge = cyc + 1;
            end
            if (bus.out_valid && !prev_ov) begin
                check_int("latency", cyc - accept_edge, NCOL);
                if (b2b && last_rise >= 0) check_int("interval", cyc - last_rise, NCOL + 2);
                last_rise = cyc;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_int("unexpected_output", 1, 0);
                end else begin
                    check_vec("result", bus.out_sh, exp_q.pop_front());
                end
                last_out = bus.out_sh;
                n_out++;
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input sh_t d);
        bit ok;
        ok = 1'b0;
        bus.in_sh    = d;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_int("accept_timeout", 0, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int count);
        int  target;
        bit  ok;
        target = n_out + count;
        ok = 1'b0;
        for (int i = 0; i < 60 * count; i++) begin
            @(posedge clk);
            if (n_out >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_int("result_timeout", n_out, target);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sh_t d, e, y, snap;
        st_t x, a, b, c;
        int  start;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sh     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_int("reset_in_ready", int'(bus.in_ready), 1);
        check_int("reset_out_valid", int'(bus.out_valid), 0);
        check_int("reset_busy", int'(busy), 0);
        check_vec("reset_out_sh", bus.out_sh, '0);
        rst = 1'b0;

        // Single non-zero column in share 0
        d = '0;
        d[4:0] = 5'd1; d[9:5] = 5'd2; d[14:10] = 5'd4; d[19:15] = 5'd8;
        e = '0;
        e[4:0] = 5'd14; e[9:5] = 5'd13; e[14:10] = 5'd11; e[19:15] = 5'd7;
        send(d);
        wait_results(1);
        check_vec("single_column", last_out, e);

        // Involution: two passes restore every share
        x = rand_st(); a = rand_st(); b = rand_st();
        d = {x ^ a ^ b, b, a};
        send(d);
        wait_results(1);
        y = last_out;
        check_vec("first_pass_unshared", sh_t'(xor_shares(y)), sh_t'(ref_mix(x)));
        send(y);
        wait_results(1);
        check_vec("involution_shares", last_out, d);
        check_vec("involution_unshared", sh_t'(xor_shares(last_out)), sh_t'(x));

        // Linearity and share separation
        a = rand_st(); b = rand_st(); c = rand_st();
        send({c, b, a});
        wait_results(1);
        check_vec("linearity", sh_t'(xor_shares(last_out)), sh_t'(ref_mix(a ^ b ^ c)));
        send({st_t'(0), st_t'(0), a});
        wait_results(1);
        check_vec("separation_zero_shares", sh_t'(last_out[TW-1:SW]), '0);
        check_vec("separation_share0", sh_t'(last_out[SW-1:0]), sh_t'(ref_mix(a)));

        // Backpressure in DONE with in_valid pulses
        bus.out_ready = 1'b0;
        send(rand_sh());
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        check_int("bp_out_valid", int'(bus.out_valid), 1);
        snap = bus.out_sh;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.in_sh    = rand_sh();
            @(negedge clk);
            check_int("bp_in_ready", int'(bus.in_ready), 0);
            check_int("bp_hold_valid", int'(bus.out_valid), 1);
            check_vec("bp_stable", bus.out_sh, snap);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_results(1);
        check_int("bp_idle_ready", int'(bus.in_ready), 1);
        send(rand_sh());
        wait_results(1);

        // Reset at col == 3 discards the partial state
        send(rand_sh());
        repeat (3) @(posedge clk);
        #1;
        check_int("busy_in_run", int'(busy), 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_int("midrst_in_ready", int'(bus.in_ready), 1);
        check_int("midrst_out_valid", int'(bus.out_valid), 0);
        check_int("midrst_busy", int'(busy), 0);
        check_vec("midrst_out_sh", bus.out_sh, '0);
        start = n_out;
        repeat (12) @(posedge clk);
        #1;
        check_int("midrst_no_output", n_out, start);
        send(rand_sh());
        wait_results(1);

        // Back-to-back with in_valid and out_ready held high
        b2b       = 1'b1;
        last_rise = -1;
        start     = n_out;
        for (int k = 0; k < 4; k++) send(rand_sh());
        wait_results(start + 4 - n_out);
        check_int("b2b_count", n_out - start, 4);
        b2b = 1'b0;

        repeat (5) @(posedge clk);
        check_int("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/fides_imixcol_serial.md
Name: fides_imixcol_serial

Overview:
- Column-serial inverse MixColumns for the threshold-implemented Fides-160 decryption datapath.
- Takes all shares of a 160-bit state (4 rows x 8 columns of 5-bit elements) and transforms one column per clock cycle.
- Each share is transformed independently, with no cross-share mixing. The operation is linear, so first-order TI share separation is kept.
- The Fides MixColumns matrix (0 1 1 1 circulant over GF(2)^5) is an involution. Inverse and forward are therefore the same row function: each output element is the XOR of the other three elements of its column.

Parameters:
- NSH, 3, number of Boolean shares
- NCOL, 8, columns per state
- W, 5, element width in bits (state width = 4*NCOL*W = 160)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input state shares present
- in_ready  output  1  block can accept a state
- in_sh  input  NSH*160  input shares; share s occupies bits [160s+159:160s]
- out_valid  output  1  result shares valid
- out_ready  input  1  downstream accepts result
- out_sh  output  NSH*160  result shares, same packing as in_sh
- busy  output  1  high while in RUN

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (rst). Element packing within each share: element e = 4*c + r (column c, row r) at bits [W*e+W-1:W*e].
- Per-column function per share: y_r = x_(r+1 mod 4) ^ x_(r+2 mod 4) ^ x_(r+3 mod 4), bitwise on W bits. No carries, no width growth.
- FSM states:
  - IDLE: in_ready=1. in_valid&&in_ready at an edge captures in_sh into the state registers, clears column counter col=0, and goes to RUN.
  - RUN: each edge replaces column col of every share with its transformed value, then col increments.
    - On the edge where col==NCOL-1, go to DONE.
    - Alternative implementation allowed: rotate the state by one column per cycle and transform a fixed column position. Final ordering must be identical.
  - DONE: out_valid=1 and out_sh holds the full transformed state, both stable until the out_valid&&out_ready edge, then return to IDLE.
- Latency: out_valid rises NCOL (=8) edges after the accepting edge. Minimum initiation interval is NCOL+2 cycles.
- in_ready=0 in RUN and DONE. in_valid during those states is ignored and nothing is captured.
- out_ready is ignored outside DONE. If out_ready is already high when DONE is entered, the handshake completes on the next edge (1 cycle in DONE).
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.
- Reset values (rst high at an edge, any state, including mid-RUN or DONE): state=IDLE, col=0, in_ready=1 after reset, out_valid=0, busy=0, out_sh=0. A partially transformed state is discarded and no output is produced for it.
- out_sh outside DONE reflects the internal registers. It is don't-care and must not be sampled.
- Shares never combine: changing share s of the input changes only share s of the output.

Test Plan:
- Single column: share0 column0 = {r0=1,r1=2,r2=4,r3=8}, all other elements and shares 0 -> share0 column0 = {14,13,11,7}, everything else 0, out_valid exactly 8 edges after accept.
- Involution: random 160-bit unshared state X split into 3 random shares; pass twice through the block -> XOR of the output shares equals X, and each share individually equals its own input share.
- Linearity/share separation: random shares A,B,C -> XOR of output shares equals MixColumns(A^B^C); with B=C=0, output shares 1 and 2 are all-zero.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid meanwhile -> out_sh stable, in_ready=0, no second capture; raise out_ready -> IDLE next cycle, then a new accept.
- Reset mid-operation: assert rst at col=3 -> next cycle in_ready=1, out_valid=0, busy=0; a fresh state then completes correctly in 8 cycles.
- Back-to-back: in_valid and out_ready held high, 4 random states -> 4 correct results, one every NCOL+2 cycles, none lost or duplicated.
